// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the multi-channel debouncer.
package debounce_pkg;

  localparam int DEF_CNT_N    = 7;
  localparam int DEF_PRESCALE = 1;
  localparam int DEF_HOLD_N   = 0;

  // Bit width needed to count 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, stability down-counter, debounced
// level with registered edge pulses, and optional long-press detector.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_N     = DEF_CNT_N,
  parameter int HOLD_N    = DEF_HOLD_N,
  parameter bit RST_LEVEL = 1'b1,
  parameter bit PRESS_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam int CNT_BIT = clog2_min1(CNT_N + 1);

  logic               sync_a;
  logic               sync_b;
  logic [CNT_BIT-1:0] cnt;
  logic               flip;
  logic               level_nxt;

  always_comb begin
    flip      = tick && (sync_b != level) && (cnt == '0);
    level_nxt = level ^ flip;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= RST_LEVEL;
      sync_b <= RST_LEVEL;
      level  <= RST_LEVEL;
      cnt    <= CNT_BIT'(CNT_N);
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      level  <= level_nxt;
      rise   <= flip & ~level;
      fall   <= flip & level;
      // Any matching tick reloads, so a single bounce restarts the whole window.
      if (tick) begin
        if ((sync_b == level) || (cnt == '0)) cnt <= CNT_BIT'(CNT_N);
        else                                  cnt <= cnt - 1'b1;
      end
    end
  end

  generate
    if (HOLD_N > 0) begin : g_hold
      localparam int HOLD_BIT = clog2_min1(HOLD_N + 1);
      logic [HOLD_BIT-1:0] hcnt;

      // Only ticks where the level was already pressed before and after the
      // edge are counted, so the press-edge tick is skipped and release clears at once.
      always_ff @(posedge clk) begin
        if (rst) begin
          hcnt <= '0;
          hold <= 1'b0;
        end else begin
          hold <= 1'b0;
          if (level_nxt != PRESS_LVL) begin
            hcnt <= '0;
          end else if ((level == PRESS_LVL) && tick && (hcnt != HOLD_BIT'(HOLD_N))) begin
            hcnt <= hcnt + 1'b1;
            hold <= (hcnt == HOLD_BIT'(HOLD_N - 1));
          end
        end
      end
    end else begin : g_no_hold
      assign hold = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/multi_debounce.sv
// CH-channel button/switch debouncer with a shared sample-rate prescaler.
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int CH        = 4,
  parameter int CNT_N     = DEF_CNT_N,
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int HOLD_N    = DEF_HOLD_N,
  parameter bit RST_LEVEL = 1'b1,
  parameter bit PRESS_LVL = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [CH-1:0] i_in,
  output logic [CH-1:0] o_level,
  output logic [CH-1:0] o_pos,
  output logic [CH-1:0] o_neg,
  output logic [CH-1:0] o_hold
);

  localparam int PRE_BIT = clog2_min1(PRESCALE);

  logic [PRE_BIT-1:0] pre;
  logic               tick;

  // With PRESCALE=1 the counter sits at 0 and tick stays high every cycle.
  assign tick = (pre == PRE_BIT'(PRESCALE - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst)     pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  generate
    for (genvar c = 0; c < CH; c++) begin : g_ch
      debounce_channel #(
        .CNT_N     (CNT_N),
        .HOLD_N    (HOLD_N),
        .RST_LEVEL (RST_LEVEL),
        .PRESS_LVL (PRESS_LVL)
      ) u_ch (
        .clk   (i_clk),
        .rst   (i_rst),
        .tick  (tick),
        .raw   (i_in[c]),
        .level (o_level[c]),
        .rise  (o_pos[c]),
        .fall  (o_neg[c]),
        .hold  (o_hold[c])
      );
    end
  endgenerate

endmodule
